// File: rtl/adxl345_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : adxl345_seq_if
// Brief    : 3-wire SPI pin bundle between adxl345_seq and the SDIO tristate.
// Revision : 1.0
// ============================================================================
interface adxl345_seq_if;
  logic oSPI_CSN;
  logic oSPI_CLK;
  logic oSDIO_O;
  logic oSDIO_OE;
  logic iSDIO_I;

  modport master (
    output oSPI_CSN,
    output oSPI_CLK,
    output oSDIO_O,
    output oSDIO_OE,
    input  iSDIO_I
  );

  modport slave (
    input  oSPI_CSN,
    input  oSPI_CLK,
    input  oSDIO_O,
    input  oSDIO_OE,
    output iSDIO_I
  );
endinterface
`default_nettype wire

// File: rtl/adxl345_seq.sv
`default_nettype none
// ============================================================================
// Module   : adxl345_seq
// Brief    : ADXL345 3-wire SPI configuration writer and periodic X/Y/Z reader.
// Revision : 1.0
// ============================================================================
module adxl345_seq #(
  parameter int         CLK_DIV       = 13,
  parameter int         SAMPLE_CYCLES = 500000,
  parameter logic [7:0] BW_RATE       = 8'h0A,
  parameter logic [1:0] RANGE         = 2'b00
) (
  input  wire                 iCLK,
  input  wire                 iRST,
  input  wire                 iEN,
  adxl345_seq_if.master       spi,
  output logic signed [15:0]  oX,
  output logic signed [15:0]  oY,
  output logic signed [15:0]  oZ,
  output logic                oVALID,
  output logic                oCFG_DONE,
  output logic                oBUSY
);

  localparam int CNT_W = $clog2(2 * CLK_DIV + 1);
  localparam int TMR_W = $clog2(SAMPLE_CYCLES + 1);

  localparam logic [CNT_W-1:0] c_half_last = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] c_gap_last  = CNT_W'(2 * CLK_DIV - 1);
  localparam logic [TMR_W-1:0] c_tmr_load  = TMR_W'(SAMPLE_CYCLES - 1);
  localparam logic [5:0]       c_wr_bits   = 6'd16;
  localparam logic [5:0]       c_rd_bits   = 6'd56;
  localparam logic [5:0]       c_cmd_bits  = 6'd8;
  localparam logic [7:0]       c_rd_cmd    = 8'hF2;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_LOW   = 3'd2,
    S_HIGH  = 3'd3,
    S_HOLD  = 3'd4,
    S_GAP   = 3'd5,
    S_WAIT  = 3'd6
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [5:0]       r_bit;          // bits started in the current transaction
  logic [15:0]      r_tx;
  logic [47:0]      r_rx;
  logic             r_is_read;
  logic [1:0]       r_cfg_idx;
  logic             r_cfg_done;
  logic [TMR_W-1:0] r_timer;
  logic             r_csn;
  logic             r_sclk;
  logic             r_sdo;
  logic             r_oe;
  logic [15:0]      r_x;
  logic [15:0]      r_y;
  logic [15:0]      r_z;
  logic             r_valid;

  logic             w_last;
  logic             w_enter;
  logic             w_active_nxt;
  logic [5:0]       w_bits_total;
  logic [15:0]      w_cfg_word;

  assign w_last       = (r_state == S_GAP) ? (r_cnt == c_gap_last) : (r_cnt == c_half_last);
  assign w_enter      = (w_state_nxt != r_state);
  assign w_active_nxt = (w_state_nxt == S_SETUP) || (w_state_nxt == S_LOW) ||
                        (w_state_nxt == S_HIGH)  || (w_state_nxt == S_HOLD);
  assign w_bits_total = r_is_read ? c_rd_bits : c_wr_bits;

  // Write words are {R=0, MB=0, addr[5:0], data}
  always_comb begin
    w_cfg_word = 16'h0000;
    case (r_cfg_idx)
      2'd0:    w_cfg_word = {2'b00, 6'h31, 1'b0, 1'b1, 4'b0000, RANGE};
      2'd1:    w_cfg_word = {2'b00, 6'h2C, BW_RATE};
      default: w_cfg_word = {2'b00, 6'h2D, 8'h08};
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (iEN) w_state_nxt = S_SETUP;
      S_SETUP: if (w_last) w_state_nxt = S_LOW;
      S_LOW:   if (w_last) w_state_nxt = S_HIGH;
      S_HIGH:  if (w_last) w_state_nxt = (r_bit < w_bits_total) ? S_LOW : S_HOLD;
      S_HOLD:  if (w_last) w_state_nxt = S_GAP;
      S_GAP: begin
        if (w_last) begin
          if (!iEN)                  w_state_nxt = S_IDLE;
          else if (!r_cfg_done)      w_state_nxt = S_SETUP;
          else if (r_timer == '0)    w_state_nxt = S_SETUP;
          else                       w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        // iEN takes priority over a timer expiry in the same cycle
        if (!iEN)                 w_state_nxt = S_IDLE;
        else if (r_timer == '0)   w_state_nxt = S_SETUP;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_bit      <= '0;
      r_tx       <= '0;
      r_rx       <= '0;
      r_is_read  <= 1'b0;
      r_cfg_idx  <= '0;
      r_cfg_done <= 1'b0;
      r_timer    <= '0;
      r_csn      <= 1'b1;
      r_sclk     <= 1'b1;
      r_sdo      <= 1'b0;
      r_oe       <= 1'b0;
      r_x        <= '0;
      r_y        <= '0;
      r_z        <= '0;
      r_valid    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_valid <= 1'b0;
      r_csn   <= !w_active_nxt;
      r_sclk  <= (w_state_nxt != S_LOW);

      if (w_enter || r_state == S_IDLE || r_state == S_WAIT)
        r_cnt <= '0;
      else
        r_cnt <= r_cnt + CNT_W'(1);

      if (w_enter && w_state_nxt == S_SETUP && r_cfg_done)
        r_timer <= c_tmr_load;
      else if (r_timer != '0)
        r_timer <= r_timer - TMR_W'(1);

      // Data bits follow the 8-bit command; capture on the SCLK rising edge
      if (r_state == S_LOW && w_last && r_is_read && r_bit > c_cmd_bits)
        r_rx <= {r_rx[46:0], spi.iSDIO_I};

      if (w_enter) begin
        case (w_state_nxt)
          S_SETUP: begin
            r_is_read <= r_cfg_done;
            r_tx      <= r_cfg_done ? {c_rd_cmd, 8'h00} : w_cfg_word;
            r_bit     <= '0;
            r_oe      <= 1'b1;
          end
          S_LOW: begin
            r_sdo <= r_tx[15];
            r_tx  <= {r_tx[14:0], 1'b0};
            r_bit <= r_bit + 6'd1;
            if (r_is_read && r_bit == c_cmd_bits)
              r_oe <= 1'b0;
          end
          S_GAP: begin
            r_oe <= 1'b0;
            if (r_is_read) begin
              r_x     <= {r_rx[39:32], r_rx[47:40]};
              r_y     <= {r_rx[23:16], r_rx[31:24]};
              r_z     <= {r_rx[7:0],   r_rx[15:8]};
              r_valid <= 1'b1;
            end else if (r_cfg_idx == 2'd2) begin
              r_cfg_done <= 1'b1;
            end else begin
              r_cfg_idx <= r_cfg_idx + 2'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign spi.oSPI_CSN = r_csn;
  assign spi.oSPI_CLK = r_sclk;
  assign spi.oSDIO_O  = r_sdo;
  assign spi.oSDIO_OE = r_oe;
  assign oX           = r_x;
  assign oY           = r_y;
  assign oZ           = r_z;
  assign oVALID       = r_valid;
  assign oCFG_DONE    = r_cfg_done;
  assign oBUSY        = !r_csn;

endmodule
`default_nettype wire

// File: tb/tb_adxl345_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_adxl345_seq
// Brief    : Directed bench for adxl345_seq with a 3-wire SPI slave model.
// Revision : 1.0
// ============================================================================
module tb_adxl345_seq;

  localparam int CLK_DIV     = 13;
  localparam int SAMPLE      = 4000;
  localparam int WR_W        = 442;
  localparam int RD_W        = 1482;
  localparam int FIRST_VALID = 3 * (442 + 26) + 1482;
  localparam logic [47:0] RESP = 48'h3412FEFF0001;

  logic iCLK = 1'b0;
  logic iRST = 1'b1;
  logic iEN  = 1'b0;
  logic signed [15:0] oX, oY, oZ;
  logic oVALID, oCFG_DONE, oBUSY;

  adxl345_seq_if spi ();

  adxl345_seq #(
    .CLK_DIV(CLK_DIV), .SAMPLE_CYCLES(SAMPLE), .BW_RATE(8'h0A), .RANGE(2'b00)
  ) dut (
    .iCLK(iCLK), .iRST(iRST), .iEN(iEN), .spi(spi),
    .oX(oX), .oY(oY), .oZ(oZ),
    .oVALID(oVALID), .oCFG_DONE(oCFG_DONE), .oBUSY(oBUSY)
  );

  always #10 iCLK = ~iCLK;

  typedef struct {
    logic [15:0] word;
    logic [7:0]  cmd;
    int          nbits;
    int          width;
    bit          oe_bad;
    logic        cfg_done;
  } txn_t;

  int n_checks = 0;
  int n_fail   = 0;

  // Slave model and timing monitor state, written only by the monitor
  int          cyc = 0;
  logic        p_csn = 1'b1, p_sclk = 1'b1;
  int          nbits, width, last_tog, ntog;
  logic [15:0] word;
  logic [7:0]  cmd;
  bit          oe_bad;
  int          hp_min = 1000000, hp_max = 0;
  int          vlen = 0;
  txn_t        q_txn[$];
  int          q_fall[$];
  int          q_valid[$];
  int          q_vlen[$];

  always @(negedge iCLK) begin
    cyc++;
    if (spi.oSPI_CSN) spi.iSDIO_I = 1'b0;
    if (p_csn && !spi.oSPI_CSN) begin
      nbits = 0; width = 0; word = '0; cmd = '0; oe_bad = 0; ntog = 0;
      q_fall.push_back(cyc);
    end
    if (!spi.oSPI_CSN) begin
      width++;
      if (spi.oSPI_CLK != p_sclk) begin
        if (ntog > 0) begin
          if (cyc - last_tog < hp_min) hp_min = cyc - last_tog;
          if (cyc - last_tog > hp_max) hp_max = cyc - last_tog;
        end
        ntog++;
        last_tog = cyc;
        if (spi.oSPI_CLK) begin
          if (nbits < 16) word = {word[14:0], spi.oSDIO_O};
          if (nbits == 7) cmd = word[7:0];
          if (nbits >= 8 && cmd == 8'hF2 && spi.oSDIO_OE) oe_bad = 1;
          nbits++;
        end else if (cmd == 8'hF2 && nbits >= 8 && nbits < 56) begin
          spi.iSDIO_I = RESP[47 - (nbits - 8)];
        end
      end
    end
    if (!p_csn && spi.oSPI_CSN)
      q_txn.push_back('{word, cmd, nbits, width, oe_bad, oCFG_DONE});
    if (oVALID) begin
      if (vlen == 0) q_valid.push_back(cyc);
      vlen++;
    end else if (vlen > 0) begin
      q_vlen.push_back(vlen);
      vlen = 0;
    end
    p_csn  = spi.oSPI_CSN;
    p_sclk = spi.oSPI_CLK;
  end

  task automatic test_reset();
    logic [7:0] outs;
    iRST = 1'b1;
    iEN  = 1'b1;
    repeat (5) @(negedge iCLK);
    outs = {spi.oSPI_CSN, spi.oSPI_CLK, spi.oSDIO_O, spi.oSDIO_OE,
            oVALID, oCFG_DONE, oBUSY, 1'b0};
    n_checks++;
    if (outs !== 8'b1100_0000) begin
      n_fail++; $display("FAIL reset_ctrl: got %b expected %b", outs, 8'b1100_0000);
    end
    n_checks++;
    if ({oX, oY, oZ} !== 48'h0) begin
      n_fail++; $display("FAIL reset_data: got %h expected 0", {oX, oY, oZ});
    end
    iRST = 1'b0;
    @(negedge iCLK);
    n_checks++;
    if ({spi.oSPI_CSN, oBUSY} !== 2'b01) begin
      n_fail++; $display("FAIL reset_exit_csn: got csn,busy=%b expected 01", {spi.oSPI_CSN, oBUSY});
    end
  endtask

  task automatic test_config();
    logic [15:0] exp_w [3];
    logic        exp_d [3];
    int k = 0;
    exp_w[0] = 16'h3140; exp_w[1] = 16'h2C0A; exp_w[2] = 16'h2D08;
    exp_d[0] = 1'b0;     exp_d[1] = 1'b0;     exp_d[2] = 1'b1;
    while (q_txn.size() < 3 && k < 3000) begin @(negedge iCLK); k++; end
    n_checks++;
    if (q_txn.size() < 3) begin
      n_fail++; $display("FAIL cfg_timeout: got %0d txns expected 3", q_txn.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_checks++;
        if (q_txn[i].word !== exp_w[i] || q_txn[i].nbits != 16 || q_txn[i].width != WR_W) begin
          n_fail++;
          $display("FAIL cfg_word%0d: got %h/%0d bits/%0d cyc expected %h/16/%0d",
                   i, q_txn[i].word, q_txn[i].nbits, q_txn[i].width, exp_w[i], WR_W);
        end
        n_checks++;
        if (q_txn[i].cfg_done !== exp_d[i]) begin
          n_fail++; $display("FAIL cfg_done%0d: got %b expected %b", i, q_txn[i].cfg_done, exp_d[i]);
        end
      end
      n_checks++;
      if (q_fall[1] - q_fall[0] != WR_W + 2 * CLK_DIV) begin
        n_fail++; $display("FAIL cfg_spacing: got %0d expected %0d", q_fall[1] - q_fall[0], WR_W + 2 * CLK_DIV);
      end
    end
  endtask

  task automatic test_read();
    int k = 0;
    while (q_valid.size() < 1 && k < 3000) begin @(negedge iCLK); k++; end
    n_checks++;
    if (q_valid.size() < 1) begin
      n_fail++; $display("FAIL read_timeout: no oVALID expected one");
      return;
    end
    n_checks++;
    if ({oX, oY, oZ} !== 48'h1234_FFFE_0100) begin
      n_fail++; $display("FAIL read_data: got %h expected 1234fffe0100", {oX, oY, oZ});
    end
    n_checks++;
    if (q_valid[0] - q_fall[0] != FIRST_VALID) begin
      n_fail++; $display("FAIL first_valid: got %0d expected %0d", q_valid[0] - q_fall[0], FIRST_VALID);
    end
    repeat (2) @(negedge iCLK);
    n_checks++;
    if (q_vlen.size() < 1 || q_vlen[0] != 1) begin
      n_fail++; $display("FAIL valid_width: got %0d entries expected width 1", q_vlen.size());
    end
    n_checks++;
    if (q_txn.size() < 4 || q_txn[3].cmd !== 8'hF2 || q_txn[3].nbits != 56 ||
        q_txn[3].width != RD_W || q_txn[3].oe_bad) begin
      n_fail++; $display("FAIL read_txn: got %0d txns expected cmd f2/56 bits/%0d cyc/OE low", q_txn.size(), RD_W);
    end
  endtask

  task automatic test_period();
    int k = 0;
    while (q_valid.size() < 3 && k < 10000) begin @(negedge iCLK); k++; end
    repeat (2) @(negedge iCLK);
    n_checks++;
    if (q_valid.size() < 3) begin
      n_fail++; $display("FAIL period_timeout: got %0d valids expected 3", q_valid.size());
      return;
    end
    for (int i = 1; i < 3; i++) begin
      n_checks++;
      if (q_valid[i] - q_valid[i-1] != SAMPLE) begin
        n_fail++; $display("FAIL period%0d: got %0d expected %0d", i, q_valid[i] - q_valid[i-1], SAMPLE);
      end
    end
    foreach (q_txn[i]) begin
      if (q_txn[i].cmd == 8'hF2) begin
        n_checks++;
        if (q_txn[i].width != RD_W || q_txn[i].oe_bad || q_txn[i].nbits != 56) begin
          n_fail++; $display("FAIL read_width%0d: got %0d expected %0d", i, q_txn[i].width, RD_W);
        end
      end
    end
    foreach (q_vlen[i]) begin
      n_checks++;
      if (q_vlen[i] != 1) begin
        n_fail++; $display("FAIL valid_len%0d: got %0d expected 1", i, q_vlen[i]);
      end
    end
    n_checks++;
    if (hp_min != CLK_DIV || hp_max != CLK_DIV) begin
      n_fail++; $display("FAIL half_period: got %0d..%0d expected %0d", hp_min, hp_max, CLK_DIV);
    end
  endtask

  task automatic test_reset_mid_read();
    int k = 0;
    while (!(!spi.oSPI_CSN && cmd == 8'hF2 && nbits > 20) && k < 6000) begin @(negedge iCLK); k++; end
    n_checks++;
    if (k >= 6000) begin
      n_fail++; $display("FAIL midread_timeout: no read in progress expected one");
      return;
    end
    iRST = 1'b1;
    @(negedge iCLK);
    n_checks++;
    if ({spi.oSPI_CSN, spi.oSPI_CLK, oCFG_DONE} !== 3'b110) begin
      n_fail++; $display("FAIL midread_ctrl: got %b expected 110", {spi.oSPI_CSN, spi.oSPI_CLK, oCFG_DONE});
    end
    n_checks++;
    if ({oX, oY, oZ} !== 48'h0) begin
      n_fail++; $display("FAIL midread_data: got %h expected 0", {oX, oY, oZ});
    end
    repeat (2) @(negedge iCLK);
    q_txn.delete();
    iRST = 1'b0;
    k = 0;
    while (q_txn.size() < 1 && k < 1000) begin @(negedge iCLK); k++; end
    n_checks++;
    if (q_txn.size() < 1 || q_txn[0].word !== 16'h3140) begin
      n_fail++; $display("FAIL midread_restart: got %0d txns expected word 3140", q_txn.size());
    end
  endtask

  task automatic test_en_toggle();
    int k = 0;
    int nv, nf, nt;
    while (!(oCFG_DONE && !spi.oSPI_CSN && cmd == 8'hF2 && nbits > 20) && k < 4000) begin
      @(negedge iCLK); k++;
    end
    n_checks++;
    if (k >= 4000) begin
      n_fail++; $display("FAIL en_timeout: no read in progress expected one");
      return;
    end
    nv = q_valid.size();
    iEN = 1'b0;
    k = 0;
    while (q_valid.size() == nv && k < 2000) begin @(negedge iCLK); k++; end
    n_checks++;
    if (q_valid.size() == nv) begin
      n_fail++; $display("FAIL en_low_valid: got no oVALID expected one");
    end
    n_checks++;
    if ({oX, oY, oZ} !== 48'h1234_FFFE_0100) begin
      n_fail++; $display("FAIL en_low_data: got %h expected 1234fffe0100", {oX, oY, oZ});
    end
    nf = q_fall.size();
    repeat (6000) @(negedge iCLK);
    n_checks++;
    if (q_fall.size() != nf || oBUSY !== 1'b0) begin
      n_fail++; $display("FAIL en_low_idle: got %0d new CSN falls busy=%b expected 0/0", q_fall.size() - nf, oBUSY);
    end
    nt = q_txn.size();
    iEN = 1'b1;
    k = 0;
    while (q_txn.size() == nt && k < 2000) begin @(negedge iCLK); k++; end
    n_checks++;
    if (q_txn.size() == nt || q_txn[nt].cmd !== 8'hF2 || q_txn[nt].nbits != 56) begin
      n_fail++; $display("FAIL en_resume: got %0d new txns expected one read (cmd f2)", q_txn.size() - nt);
    end
  endtask

  initial begin
    test_reset();
    test_config();
    test_read();
    test_period();
    test_reset_mid_read();
    test_en_toggle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
